// File: rtl/complete_stage_pkg.sv
// Shared types and constants for the completion / reorder-buffer stage.
// Optional feature macro: COMPLETE_DUAL_RETIRE_EN (dual retirement per cycle).
package complete_stage_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int ROB_CNT_W = ROB_IDX_W + 1;
    localparam int NUM_FU    = 3;
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;

    // One reorder-buffer entry.
    typedef struct packed {
        logic        v;
        logic        instr_type;   // 1 = store, frees no physical register
        logic [5:0]  phy_reg;
        logic [5:0]  old_phy;
        logic [31:0] result;
        logic        comp;
    } rob_row;

    // Fresh entry for a newly dispatched instruction.
    function automatic rob_row make_row(input logic [6:0] opcode,
                                        input logic [5:0] p_reg,
                                        input logic [5:0] o_p_reg);
        rob_row r;
        r.v          = 1'b1;
        r.instr_type = (opcode == STORE_OPCODE);
        r.phy_reg    = p_reg;
        r.old_phy    = o_p_reg;
        r.result     = '0;
        r.comp       = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/complete_stage.sv
// Completion stage: 16-entry circular reorder buffer with dual allocation,
// three completion ports with registered forwarding, and in-order retirement
// that returns old physical registers to the free pool.
// Optional feature macro: COMPLETE_DUAL_RETIRE_EN -- when defined, up to two
// entries retire per cycle; otherwise only slot 1 retires.
module complete_stage
    import complete_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_flag_ci,
    input  logic [31:0]          result_c1,
    input  logic [31:0]          result_c2,
    input  logic [31:0]          result_c3,
    input  logic [5:0]           result_dest_c1,
    input  logic [5:0]           result_dest_c2,
    input  logic [5:0]           result_dest_c3,
    input  logic                 result_valid_c1,
    input  logic                 result_valid_c2,
    input  logic                 result_valid_c3,
    input  logic [ROB_IDX_W-1:0] result_ROB_c1,
    input  logic [ROB_IDX_W-1:0] result_ROB_c2,
    input  logic [ROB_IDX_W-1:0] result_ROB_c3,
    input  logic [1:0]           result_FU_c1,
    input  logic [1:0]           result_FU_c2,
    input  logic [1:0]           result_FU_c3,
    input  logic                 alloc_valid_1,
    input  logic                 alloc_valid_2,
    input  logic [5:0]           rob_p_reg_1,
    input  logic [5:0]           rob_p_reg_2,
    input  logic [6:0]           rob_opcode_1,
    input  logic [6:0]           rob_opcode_2,
    input  logic [5:0]           o_rob_p_reg_1,
    input  logic [5:0]           o_rob_p_reg_2,
    output logic [ROB_IDX_W-1:0] rob_tail,
    output logic                 rob_ready,
    output logic                 en_flag_co,
    output logic                 forward_flag_1,
    output logic                 forward_flag_2,
    output logic                 forward_flag_3,
    output logic [5:0]           dest_R_1,
    output logic [5:0]           dest_R_2,
    output logic [5:0]           dest_R_3,
    output logic [31:0]          forwarded_data_1,
    output logic [31:0]          forwarded_data_2,
    output logic [31:0]          forwarded_data_3,
    output logic                 retire_flag_1,
    output logic                 retire_flag_2,
    output logic [5:0]           fp_ind_1,
    output logic [5:0]           fp_ind_2
);

    // Completion ports gathered into arrays, index 0 = port 1.
    logic [NUM_FU-1:0]    res_valid;
    logic [31:0]          res_data [NUM_FU];
    logic [5:0]           res_dest [NUM_FU];
    logic [ROB_IDX_W-1:0] res_rob  [NUM_FU];

    assign res_valid   = {result_valid_c3, result_valid_c2, result_valid_c1};
    assign res_data[0] = result_c1;
    assign res_data[1] = result_c2;
    assign res_data[2] = result_c3;
    assign res_dest[0] = result_dest_c1;
    assign res_dest[1] = result_dest_c2;
    assign res_dest[2] = result_dest_c3;
    assign res_rob[0]  = result_ROB_c1;
    assign res_rob[1]  = result_ROB_c2;
    assign res_rob[2]  = result_ROB_c3;

    rob_row               rob_q [ROB_DEPTH];
    rob_row               rob_d [ROB_DEPTH];
    logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_CNT_W-1:0] count_q, count_d;
    logic                 en_flag_q, en_flag_d;
    logic [NUM_FU-1:0]    fwd_flag_q, fwd_flag_d;
    logic [5:0]           fwd_dest_q [NUM_FU];
    logic [5:0]           fwd_dest_d [NUM_FU];
    logic [31:0]          fwd_data_q [NUM_FU];
    logic [31:0]          fwd_data_d [NUM_FU];
    logic                 ret_flag_1_q, ret_flag_1_d, ret_flag_2_q, ret_flag_2_d;
    logic [5:0]           fp_ind_1_q, fp_ind_1_d, fp_ind_2_q, fp_ind_2_d;

    logic [ROB_CNT_W-1:0] n_req, n_alloc, n_ret, free_slots;
    logic                 alloc_ok, ret1, ret2;
    logic [ROB_IDX_W-1:0] slot2_idx, head_plus1;

    // Next-state: completion, then allocation, then retirement, all judged on start-of-cycle state.
    always_comb begin
        rob_d      = rob_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        en_flag_d  = en_flag_ci;
        fwd_flag_d = '0;
        fwd_dest_d = fwd_dest_q;
        fwd_data_d = fwd_data_q;

        n_req      = ROB_CNT_W'(alloc_valid_1) + ROB_CNT_W'(alloc_valid_2);
        free_slots = ROB_CNT_W'(ROB_DEPTH) - count_q;
        alloc_ok   = (free_slots >= n_req);
        n_alloc    = alloc_ok ? n_req : '0;
        slot2_idx  = alloc_valid_1 ? tail_q + ROB_IDX_W'(1) : tail_q;
        head_plus1 = head_q + ROB_IDX_W'(1);

        ret1 = rob_q[head_q].v && rob_q[head_q].comp;
`ifdef COMPLETE_DUAL_RETIRE_EN
        ret2 = ret1 && rob_q[head_plus1].v && rob_q[head_plus1].comp;
`else
        ret2 = 1'b0;
`endif
        n_ret = ROB_CNT_W'(ret1) + ROB_CNT_W'(ret2);

        // Ascending port order so the highest port wins a shared index.
        for (int k = 0; k < NUM_FU; k++) begin
            if (en_flag_ci && res_valid[k]) begin
                fwd_flag_d[k] = 1'b1;
                fwd_dest_d[k] = res_dest[k];
                fwd_data_d[k] = res_data[k];
                if (rob_q[res_rob[k]].v) begin
                    rob_d[res_rob[k]].result = res_data[k];
                    rob_d[res_rob[k]].comp   = 1'b1;
                end
            end
        end

        if (alloc_ok && alloc_valid_1) begin
            rob_d[tail_q] = make_row(rob_opcode_1, rob_p_reg_1, o_rob_p_reg_1);
        end
        if (alloc_ok && alloc_valid_2) begin
            rob_d[slot2_idx] = make_row(rob_opcode_2, rob_p_reg_2, o_rob_p_reg_2);
        end

        if (ret1) begin
            rob_d[head_q].v    = 1'b0;
            rob_d[head_q].comp = 1'b0;
        end
        if (ret2) begin
            rob_d[head_plus1].v    = 1'b0;
            rob_d[head_plus1].comp = 1'b0;
        end

        // Stores retire without returning a register to the free pool.
        ret_flag_1_d = ret1 && !rob_q[head_q].instr_type;
        fp_ind_1_d   = ret_flag_1_d ? rob_q[head_q].old_phy : '0;
        ret_flag_2_d = ret2 && !rob_q[head_plus1].instr_type;
        fp_ind_2_d   = ret_flag_2_d ? rob_q[head_plus1].old_phy : '0;

        tail_d  = tail_q + n_alloc[ROB_IDX_W-1:0];
        head_d  = head_q + n_ret[ROB_IDX_W-1:0];
        count_d = count_q + n_alloc - n_ret;
    end

    // State registers with synchronous reset that discards all in-flight entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            en_flag_q    <= 1'b0;
            fwd_flag_q   <= '0;
            for (int k = 0; k < NUM_FU; k++) begin
                fwd_dest_q[k] <= '0;
                fwd_data_q[k] <= '0;
            end
            ret_flag_1_q <= 1'b0;
            ret_flag_2_q <= 1'b0;
            fp_ind_1_q   <= '0;
            fp_ind_2_q   <= '0;
        end else begin
            rob_q        <= rob_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            en_flag_q    <= en_flag_d;
            fwd_flag_q   <= fwd_flag_d;
            fwd_dest_q   <= fwd_dest_d;
            fwd_data_q   <= fwd_data_d;
            ret_flag_1_q <= ret_flag_1_d;
            ret_flag_2_q <= ret_flag_2_d;
            fp_ind_1_q   <= fp_ind_1_d;
            fp_ind_2_q   <= fp_ind_2_d;
        end
    end

    assign rob_tail         = tail_q;
    assign rob_ready        = (ROB_CNT_W'(ROB_DEPTH) - count_q) >= ROB_CNT_W'(2);
    assign en_flag_co       = en_flag_q;
    assign forward_flag_1   = fwd_flag_q[0];
    assign forward_flag_2   = fwd_flag_q[1];
    assign forward_flag_3   = fwd_flag_q[2];
    assign dest_R_1         = fwd_dest_q[0];
    assign dest_R_2         = fwd_dest_q[1];
    assign dest_R_3         = fwd_dest_q[2];
    assign forwarded_data_1 = fwd_data_q[0];
    assign forwarded_data_2 = fwd_data_q[1];
    assign forwarded_data_3 = fwd_data_q[2];
    assign retire_flag_1    = ret_flag_1_q;
    assign fp_ind_1         = fp_ind_1_q;
`ifdef COMPLETE_DUAL_RETIRE_EN
    assign retire_flag_2    = ret_flag_2_q;
    assign fp_ind_2         = fp_ind_2_q;
`else
    assign retire_flag_2    = 1'b0;
    assign fp_ind_2         = '0;
`endif

    // FU ids and stored results/phy_reg are kept for debug visibility only.
    logic unused_sink;
    assign unused_sink = ^{result_FU_c1, result_FU_c2, result_FU_c3,
                           rob_q[head_q].result, rob_q[head_q].phy_reg,
                           ret_flag_2_q, fp_ind_2_q};

endmodule

// File: tb/tb_complete_stage.sv
// Directed self-checking bench for complete_stage: table-driven forwarding
// vectors plus hand-written ROB allocation/completion/retirement sequences.
module tb_complete_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_flag_ci;
    logic [31:0] result_c1, result_c2, result_c3;
    logic [5:0]  result_dest_c1, result_dest_c2, result_dest_c3;
    logic        result_valid_c1, result_valid_c2, result_valid_c3;
    logic [3:0]  result_ROB_c1, result_ROB_c2, result_ROB_c3;
    logic [1:0]  result_FU_c1, result_FU_c2, result_FU_c3;
    logic        alloc_valid_1, alloc_valid_2;
    logic [5:0]  rob_p_reg_1, rob_p_reg_2;
    logic [6:0]  rob_opcode_1, rob_opcode_2;
    logic [5:0]  o_rob_p_reg_1, o_rob_p_reg_2;
    logic [3:0]  rob_tail;
    logic        rob_ready, en_flag_co;
    logic        forward_flag_1, forward_flag_2, forward_flag_3;
    logic [5:0]  dest_R_1, dest_R_2, dest_R_3;
    logic [31:0] forwarded_data_1, forwarded_data_2, forwarded_data_3;
    logic        retire_flag_1, retire_flag_2;
    logic [5:0]  fp_ind_1, fp_ind_2;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    always #5 clk = ~clk;

    complete_stage dut (
        .clk(clk), .rst(rst), .en_flag_ci(en_flag_ci),
        .result_c1(result_c1), .result_c2(result_c2), .result_c3(result_c3),
        .result_dest_c1(result_dest_c1), .result_dest_c2(result_dest_c2), .result_dest_c3(result_dest_c3),
        .result_valid_c1(result_valid_c1), .result_valid_c2(result_valid_c2), .result_valid_c3(result_valid_c3),
        .result_ROB_c1(result_ROB_c1), .result_ROB_c2(result_ROB_c2), .result_ROB_c3(result_ROB_c3),
        .result_FU_c1(result_FU_c1), .result_FU_c2(result_FU_c2), .result_FU_c3(result_FU_c3),
        .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
        .rob_p_reg_1(rob_p_reg_1), .rob_p_reg_2(rob_p_reg_2),
        .rob_opcode_1(rob_opcode_1), .rob_opcode_2(rob_opcode_2),
        .o_rob_p_reg_1(o_rob_p_reg_1), .o_rob_p_reg_2(o_rob_p_reg_2),
        .rob_tail(rob_tail), .rob_ready(rob_ready), .en_flag_co(en_flag_co),
        .forward_flag_1(forward_flag_1), .forward_flag_2(forward_flag_2), .forward_flag_3(forward_flag_3),
        .dest_R_1(dest_R_1), .dest_R_2(dest_R_2), .dest_R_3(dest_R_3),
        .forwarded_data_1(forwarded_data_1), .forwarded_data_2(forwarded_data_2),
        .forwarded_data_3(forwarded_data_3),
        .retire_flag_1(retire_flag_1), .retire_flag_2(retire_flag_2),
        .fp_ind_1(fp_ind_1), .fp_ind_2(fp_ind_2)
    );

    // Forwarding vector: inputs applied for one cycle, outputs expected after the edge.
    typedef struct packed {
        logic             en;
        logic [2:0]       valid;
        logic [2:0][5:0]  dest;
        logic [2:0][31:0] data;
        logic             exp_co;
        logic [2:0]       exp_ff;
        logic [2:0][5:0]  exp_dest;
        logic [2:0][31:0] exp_data;
    } fwd_vec_t;

    fwd_vec_t tv [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en_flag_ci = 0;
        result_c1 = 0; result_c2 = 0; result_c3 = 0;
        result_dest_c1 = 0; result_dest_c2 = 0; result_dest_c3 = 0;
        result_valid_c1 = 0; result_valid_c2 = 0; result_valid_c3 = 0;
        result_ROB_c1 = 0; result_ROB_c2 = 0; result_ROB_c3 = 0;
        result_FU_c1 = 0; result_FU_c2 = 1; result_FU_c3 = 2;
        alloc_valid_1 = 0; alloc_valid_2 = 0;
        rob_p_reg_1 = 0; rob_p_reg_2 = 0;
        rob_opcode_1 = 0; rob_opcode_2 = 0;
        o_rob_p_reg_1 = 0; o_rob_p_reg_2 = 0;
    endtask

    task automatic alloc1(input logic [6:0] op, input logic [5:0] p, input logic [5:0] o);
        alloc_valid_1 = 1; rob_opcode_1 = op; rob_p_reg_1 = p; o_rob_p_reg_1 = o;
    endtask

    task automatic alloc2(input logic [6:0] op, input logic [5:0] p, input logic [5:0] o);
        alloc_valid_2 = 1; rob_opcode_2 = op; rob_p_reg_2 = p; o_rob_p_reg_2 = o;
    endtask

    task automatic check_retire(input string tag, input logic f1, input logic [5:0] i1,
                                input logic f2, input logic [5:0] i2);
        check({tag, ".retire_flag_1"}, retire_flag_1, f1);
        check({tag, ".fp_ind_1"}, fp_ind_1, i1);
        check({tag, ".retire_flag_2"}, retire_flag_2, f2);
        check({tag, ".fp_ind_2"}, fp_ind_2, i2);
        $display("[%0t] %s: rf1=%0d fp1=%0d rf2=%0d fp2=%0d tail=%0d ready=%0d",
                 $time, tag, retire_flag_1, fp_ind_1, retire_flag_2, fp_ind_2, rob_tail, rob_ready);
    endtask

    initial begin
        // Forwarding table; every completion targets ROB 3.
        tv[0] = '{en:1'b1, valid:3'b010, dest:{6'd0, 6'd40, 6'd0},
                  data:{32'h0, 32'h0000002A, 32'h0},
                  exp_co:1'b1, exp_ff:3'b010, exp_dest:{6'd0, 6'd40, 6'd0},
                  exp_data:{32'h0, 32'h0000002A, 32'h0}};
        tv[1] = '{en:1'b1, valid:3'b101, dest:{6'd63, 6'd11, 6'd7},
                  data:{32'hFFFFFFFF, 32'h12345678, 32'hDEADBEEF},
                  exp_co:1'b1, exp_ff:3'b101, exp_dest:{6'd63, 6'd40, 6'd7},
                  exp_data:{32'hFFFFFFFF, 32'h0000002A, 32'hDEADBEEF}};
        tv[2] = '{en:1'b0, valid:3'b111, dest:{6'd3, 6'd2, 6'd1},
                  data:{32'h33, 32'h22, 32'h11},
                  exp_co:1'b0, exp_ff:3'b000, exp_dest:{6'd63, 6'd40, 6'd7},
                  exp_data:{32'hFFFFFFFF, 32'h0000002A, 32'hDEADBEEF}};
        tv[3] = '{en:1'b1, valid:3'b111, dest:{6'd3, 6'd2, 6'd1},
                  data:{32'h33, 32'h22, 32'h11},
                  exp_co:1'b1, exp_ff:3'b111, exp_dest:{6'd3, 6'd2, 6'd1},
                  exp_data:{32'h33, 32'h22, 32'h11}};
        tv[4] = '{en:1'b1, valid:3'b000, dest:{6'd9, 6'd9, 6'd9},
                  data:{32'h99, 32'h99, 32'h99},
                  exp_co:1'b1, exp_ff:3'b000, exp_dest:{6'd3, 6'd2, 6'd1},
                  exp_data:{32'h33, 32'h22, 32'h11}};
        tv[5] = '{en:1'b0, valid:3'b000, dest:{6'd0, 6'd0, 6'd0},
                  data:{32'h0, 32'h0, 32'h0},
                  exp_co:1'b0, exp_ff:3'b000, exp_dest:{6'd3, 6'd2, 6'd1},
                  exp_data:{32'h33, 32'h22, 32'h11}};

        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Reset state.
        check("reset.rob_ready", rob_ready, 1'b1);
        check("reset.rob_tail", rob_tail, 4'd0);
        check("reset.en_flag_co", en_flag_co, 1'b0);
        check("reset.forward_flags", {forward_flag_3, forward_flag_2, forward_flag_1}, 3'b000);
        check("reset.dest_R_1", dest_R_1, 6'd0);
        check("reset.forwarded_data_2", forwarded_data_2, 32'h0);
        check_retire("reset", 1'b0, 6'd0, 1'b0, 6'd0);

        // Forwarding table.
        for (int i = 0; i < 6; i++) begin
            en_flag_ci = tv[i].en;
            result_valid_c1 = tv[i].valid[0]; result_valid_c2 = tv[i].valid[1]; result_valid_c3 = tv[i].valid[2];
            result_dest_c1 = tv[i].dest[0]; result_dest_c2 = tv[i].dest[1]; result_dest_c3 = tv[i].dest[2];
            result_c1 = tv[i].data[0]; result_c2 = tv[i].data[1]; result_c3 = tv[i].data[2];
            result_ROB_c1 = 4'd3; result_ROB_c2 = 4'd3; result_ROB_c3 = 4'd3;
            tick();
            check($sformatf("fwd%0d.en_flag_co", i), en_flag_co, tv[i].exp_co);
            check($sformatf("fwd%0d.forward_flag_1", i), forward_flag_1, tv[i].exp_ff[0]);
            check($sformatf("fwd%0d.forward_flag_2", i), forward_flag_2, tv[i].exp_ff[1]);
            check($sformatf("fwd%0d.forward_flag_3", i), forward_flag_3, tv[i].exp_ff[2]);
            check($sformatf("fwd%0d.dest_R_1", i), dest_R_1, tv[i].exp_dest[0]);
            check($sformatf("fwd%0d.dest_R_2", i), dest_R_2, tv[i].exp_dest[1]);
            check($sformatf("fwd%0d.dest_R_3", i), dest_R_3, tv[i].exp_dest[2]);
            check($sformatf("fwd%0d.forwarded_data_1", i), forwarded_data_1, tv[i].exp_data[0]);
            check($sformatf("fwd%0d.forwarded_data_2", i), forwarded_data_2, tv[i].exp_data[1]);
            check($sformatf("fwd%0d.forwarded_data_3", i), forwarded_data_3, tv[i].exp_data[2]);
            $display("[%0t] fwd vector %0d: en=%0d valid=%b -> ff=%b%b%b co=%0d", $time, i,
                     tv[i].en, tv[i].valid, forward_flag_3, forward_flag_2, forward_flag_1, en_flag_co);
        end
        clear_inputs();

        // Two allocations, out-of-order completion, in-order retirement.
        alloc1(OP_ALU, 6'd33, 6'd5);
        alloc2(OP_ALU, 6'd34, 6'd6);
        tick();
        clear_inputs();
        check("alloc2.rob_tail", rob_tail, 4'd2);
        check_retire("alloc2", 1'b0, 6'd0, 1'b0, 6'd0);
        en_flag_ci = 1; result_valid_c1 = 1; result_ROB_c1 = 4'd1; result_dest_c1 = 6'd34; result_c1 = 32'h100;
        tick();
        clear_inputs();
        check_retire("comp_rob1", 1'b0, 6'd0, 1'b0, 6'd0);
        tick();
        check_retire("wait_rob0", 1'b0, 6'd0, 1'b0, 6'd0);
        en_flag_ci = 1; result_valid_c3 = 1; result_ROB_c3 = 4'd0; result_dest_c3 = 6'd33; result_c3 = 32'h200;
        tick();
        clear_inputs();
        check_retire("comp_rob0", 1'b0, 6'd0, 1'b0, 6'd0);
        tick();
`ifdef COMPLETE_DUAL_RETIRE_EN
        check_retire("retire_a", 1'b1, 6'd5, 1'b1, 6'd6);
        tick();
        check_retire("retire_b", 1'b0, 6'd0, 1'b0, 6'd0);
`else
        check_retire("retire_a", 1'b1, 6'd5, 1'b0, 6'd0);
        tick();
        check_retire("retire_b", 1'b1, 6'd6, 1'b0, 6'd0);
`endif
        tick();
        check_retire("retire_idle", 1'b0, 6'd0, 1'b0, 6'd0);

        // Store at head: frees its entry without a register return. Occupies ROB2.
        alloc1(OP_STORE, 6'd10, 6'd12);
        tick();
        clear_inputs();
        check("store.rob_tail", rob_tail, 4'd3);
        en_flag_ci = 1; result_valid_c2 = 1; result_ROB_c2 = 4'd2; result_dest_c2 = 6'd10; result_c2 = 32'h55;
        tick();
        clear_inputs();
        tick();
        check_retire("store_retire", 1'b0, 6'd0, 1'b0, 6'd0);

        // Fill 15 entries (ROB3..ROB1); succeeds only if the store's slot was freed.
        for (int i = 0; i < 7; i++) begin
            alloc1(OP_ALU, 6'(20 + 2 * i), 6'(40 + 2 * i));
            alloc2(OP_ALU, 6'(21 + 2 * i), 6'(41 + 2 * i));
            tick();
            $display("[%0t] fill pair %0d: tail=%0d ready=%0d", $time, i, rob_tail, rob_ready);
        end
        clear_inputs();
        check("fill14.rob_tail", rob_tail, 4'd1);
        check("fill14.rob_ready", rob_ready, 1'b1);
        alloc1(OP_ALU, 6'd50, 6'd60);
        tick();
        clear_inputs();
        check("fill15.rob_tail", rob_tail, 4'd2);
        check("fill15.rob_ready", rob_ready, 1'b0);
        alloc1(OP_ALU, 6'd51, 6'd61);
        alloc2(OP_ALU, 6'd52, 6'd62);
        tick();
        clear_inputs();
        check("reject2.rob_tail", rob_tail, 4'd2);
        check("reject2.rob_ready", rob_ready, 1'b0);
        alloc2(OP_ALU, 6'd53, 6'd63);
        tick();
        clear_inputs();
        check("accept1.rob_tail", rob_tail, 4'd3);
        check("accept1.rob_ready", rob_ready, 1'b0);
        alloc1(OP_ALU, 6'd54, 6'd1);
        tick();
        clear_inputs();
        check("full_reject.rob_tail", rob_tail, 4'd3);
        $display("[%0t] full ROB: tail=%0d ready=%0d", $time, rob_tail, rob_ready);

        // Complete the head, then reset before it can retire.
        en_flag_ci = 1; result_valid_c1 = 1; result_ROB_c1 = 4'd3; result_dest_c1 = 6'd20; result_c1 = 32'h77;
        tick();
        clear_inputs();
        rst = 1;
        tick();
        check("full_reset.rob_ready", rob_ready, 1'b1);
        check("full_reset.rob_tail", rob_tail, 4'd0);
        check("full_reset.en_flag_co", en_flag_co, 1'b0);
        check("full_reset.forward_flags", {forward_flag_3, forward_flag_2, forward_flag_1}, 3'b000);
        check("full_reset.dest_R_1", dest_R_1, 6'd0);
        check_retire("full_reset", 1'b0, 6'd0, 1'b0, 6'd0);
        rst = 0;
        tick();
        check_retire("after_reset", 1'b0, 6'd0, 1'b0, 6'd0);
        check("after_reset.rob_tail", rob_tail, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
